mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
Memory-access pipeline stage that consumes the execute-stage outputs (ALU result/address, store data, destination register, control) and performs loads and stores on the data-memory bus. Uses a valid/ready request and valid response handshake.
Generates byte enables, aligns store data, and extracts plus sign/zero-extends load data. Registers results for write-back. Asserts a stall to upstream while a memory transaction is outstanding.

Parameters:
DATA_WIDTH, 32, datapath and bus data width (fixed 32 for byte-enable logic)
ADDR_WIDTH, 32, data-memory byte address width
REG_FILE_ADDR, 5, destination register index width
TIMEOUT_CYCLES, 16, bus watchdog limit (used only with MEM_ACCESS_TIMEOUT_EN)

Ports:
i_clk  in  1  clock
i_reset_n  in  1  reset
i_IE_valid  in  1  execute stage presents a valid instruction
i_IE_result  in  DATA_WIDTH  ALU result / effective byte address
i_IE_data_write  in  DATA_WIDTH  store data (rs2)
i_IE_rd  in  REG_FILE_ADDR  destination register
i_ctrl_mem_read  in  1  load
i_ctrl_mem_write  in  1  store
i_ctrl_reg_write  in  1  instruction writes rd
i_ctrl_mem_size  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
o_stall  out  1  stage busy; upstream must hold and not present new work
o_dmem_req_valid  out  1  bus request valid
i_dmem_req_ready  in  1  bus accepts request
o_dmem_addr  out  ADDR_WIDTH  word-aligned address (bits [1:0]=0)
o_dmem_we  out  1  1=write
o_dmem_wdata  out  DATA_WIDTH  lane-replicated store data
o_dmem_be  out  4  byte enables
i_dmem_rsp_valid  in  1  read response valid
i_dmem_rdata  in  DATA_WIDTH  read data word
o_MEM_valid  out  1  one-cycle pulse: write-back fields updated
o_MEM_result  out  DATA_WIDTH  ALU result passed through
o_MEM_read_data  out  DATA_WIDTH  extended load data
o_MEM_rd  out  REG_FILE_ADDR  destination register
o_MEM_reg_write  out  1  write-back enable
o_MEM_mem_to_reg  out  1  select read_data over result
o_MEM_misalign  out  1  access was misaligned, suppressed
o_MEM_timeout  out  1  access aborted by watchdog

Behaviour:
- Clock and reset: single clock i_clk. i_reset_n is asynchronous, active-low. On reset, state goes to IDLE and every output is 0. An in-flight transaction is abandoned; a later i_dmem_rsp_valid is ignored because it only counts in RESP.
- FSM states: IDLE, REQ, RESP. o_stall = (state != IDLE).
- Input capture: i_IE_* are accepted only in IDLE with i_IE_valid=1, and are captured into internal registers.
- No memory op (neither read nor write): stay in IDLE. Next cycle o_MEM_valid=1 with result/rd/reg_write; mem_to_reg=0. Latency 1.
- Read and write both set: treated as store.
- Misalignment: H/HU with addr[0]=1, or W with addr[1:0]!=0. No bus request is issued. Next cycle o_MEM_valid=1, misalign=1, reg_write=0.
- Aligned load or store: IDLE→REQ. In REQ, o_dmem_req_valid=1 and addr/we/wdata/be stay stable until i_dmem_req_ready.
  - Store: when the handshake completes, go to IDLE. o_MEM_valid=1 the next cycle, reg_write=0.
  - Load: when the handshake completes, go to RESP. On i_dmem_rsp_valid, register the extended data, set mem_to_reg=1 and reg_write=captured, pulse o_MEM_valid, then go to IDLE.
  - A response in the same cycle as the request handshake is illegal and ignored.
- Minimum latency from accept: store 2 cycles, load 3 cycles.
- Store lanes:
  - B: be=1<<addr[1:0], wdata={4{data[7:0]}}
  - H: be=addr[1]?1100:0011, wdata={2{data[15:0]}}
  - W: be=1111
- Loads: select the byte/half at addr[1:0]. Sign-extend for B/H; zero-extend for BU/HU.
- o_MEM_valid is a single-cycle pulse. The other o_MEM_* outputs hold their values until the next update. misalign and timeout clear on the next o_MEM_valid.

Optional Feature:
MEM_ACCESS_TIMEOUT_EN:
- Defined: a counter clears on entering REQ and increments in REQ/RESP. When it reaches TIMEOUT_CYCLES the access aborts: o_dmem_req_valid drops, state returns to IDLE, next-cycle o_MEM_valid=1 with timeout=1, reg_write=0.
- Undefined: no counter, the stage waits indefinitely, and o_MEM_timeout is tied 0.

Decomposition:
- Package mem_pkg holds:
  - mem_size_e enum (funct3 encodings)
  - mem_state_e enum {IDLE, REQ, RESP}
  - BE_WIDTH=4 constant
- One combinational sub-module, mem_load_align (rdata, addr[1:0], size → extended data), is natural.

Test Plan:
- ALU pass-through: valid, no mem ops, result 0x12345678, rd=5, reg_write=1 → next cycle MEM_valid=1, result 0x12345678, rd=5, mem_to_reg=0, stall never high.
- SB addr 0x103, data 0x000000AB, ready high → addr 0x100, be=1000, wdata 0xABABABAB, we=1; MEM_valid one cycle after handshake, reg_write=0.
- LB addr 0x102, ready delayed 3 cycles, rsp 2 cycles later with rdata 0x00800000 → stall held throughout, read_data 0xFFFFFF80; repeat with LBU → 0x00000080.
- LH addr 0x101 → no req_valid, MEM_valid next cycle, misalign=1, reg_write=0.
- Reset pulse while in RESP → outputs 0 immediately; subsequent rsp_valid ignored; following ALU op completes normally.
- With MEM_ACCESS_TIMEOUT_EN, TIMEOUT_CYCLES=16, ready held 0 → req_valid drops after 16 cycles, MEM_valid with timeout=1.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access stage.
// Optional bus watchdog is enabled with `define MEM_ACCESS_TIMEOUT_EN.
package mem_pkg;

    localparam int BE_WIDTH = 4;

    // funct3 encodings of the access size
    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes never misalign
    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        case (size)
            MEM_H, MEM_HU: mis = lo[0];
            MEM_W:         mis = (lo != 2'b00);
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data extraction: picks the addressed byte/halfword from a 32-bit
// read word and sign- or zero-extends it according to funct3.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  size_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection and extension
    always_comb begin
        shifted  = rdata_i >> {addr_lo_i, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        data_o   = rdata_i;
        case (size_i)
            MEM_B:   data_o = {{24{byte_sel[7]}}, byte_sel};
            MEM_BU:  data_o = {24'b0, byte_sel};
            MEM_H:   data_o = {{16{half_sel[15]}}, half_sel};
            MEM_HU:  data_o = {16'b0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues loads/stores on a valid/ready data
// bus, aligns store lanes, extends load data and registers write-back fields.
// Optional bus watchdog is enabled with `define MEM_ACCESS_TIMEOUT_EN.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned REG_FILE_ADDR  = 5,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_IE_valid,
    input  logic [DATA_WIDTH-1:0]    i_IE_result,
    input  logic [DATA_WIDTH-1:0]    i_IE_data_write,
    input  logic [REG_FILE_ADDR-1:0] i_IE_rd,
    input  logic                     i_ctrl_mem_read,
    input  logic                     i_ctrl_mem_write,
    input  logic                     i_ctrl_reg_write,
    input  logic [2:0]               i_ctrl_mem_size,
    output logic                     o_stall,
    output logic                     o_dmem_req_valid,
    input  logic                     i_dmem_req_ready,
    output logic [ADDR_WIDTH-1:0]    o_dmem_addr,
    output logic                     o_dmem_we,
    output logic [DATA_WIDTH-1:0]    o_dmem_wdata,
    output logic [BE_WIDTH-1:0]      o_dmem_be,
    input  logic                     i_dmem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]    i_dmem_rdata,
    output logic                     o_MEM_valid,
    output logic [DATA_WIDTH-1:0]    o_MEM_result,
    output logic [DATA_WIDTH-1:0]    o_MEM_read_data,
    output logic [REG_FILE_ADDR-1:0] o_MEM_rd,
    output logic                     o_MEM_reg_write,
    output logic                     o_MEM_mem_to_reg,
    output logic                     o_MEM_misalign,
    output logic                     o_MEM_timeout
);

    mem_state_e state_q, state_d;

    logic [DATA_WIDTH-1:0]    result_q, wdata_q;
    logic [REG_FILE_ADDR-1:0] rd_q;
    logic                     regw_q, we_q;
    logic [2:0]               size_q;

    logic                     accept, req_valid, timeout_hit;
    logic                     mem_valid_d, regw_d, m2r_d, mis_d, to_d, load_upd;
    logic [DATA_WIDTH-1:0]    result_d;
    logic [REG_FILE_ADDR-1:0] rd_d;

    logic                     mem_valid_q, regw_wb_q, m2r_q, mis_q, to_q;
    logic [DATA_WIDTH-1:0]    result_wb_q, rdata_wb_q, load_data;
    logic [REG_FILE_ADDR-1:0] rd_wb_q;
    logic [BE_WIDTH-1:0]      be_lanes;
    logic [DATA_WIDTH-1:0]    wdata_lanes;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;

    // Watchdog: idle clears it, every busy cycle counts toward the limit
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)            cnt_q <= '0;
        else if (state_q == IDLE)  cnt_q <= '0;
        else                       cnt_q <= cnt_q + CNT_W'(1);
    end

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // Next state and write-back update; a completed handshake wins over the watchdog
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        req_valid   = 1'b0;
        mem_valid_d = 1'b0;
        result_d    = result_q;
        rd_d        = rd_q;
        regw_d      = 1'b0;
        m2r_d       = 1'b0;
        mis_d       = 1'b0;
        to_d        = 1'b0;
        load_upd    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_IE_valid) begin
                    accept   = 1'b1;
                    result_d = i_IE_result;
                    rd_d     = i_IE_rd;
                    if (!(i_ctrl_mem_read || i_ctrl_mem_write)) begin
                        mem_valid_d = 1'b1;
                        regw_d      = i_ctrl_reg_write;
                    end else if (is_misaligned(i_ctrl_mem_size, i_IE_result[1:0])) begin
                        mem_valid_d = 1'b1;
                        mis_d       = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                req_valid = 1'b1;
                if (i_dmem_req_ready) begin
                    if (we_q) begin
                        state_d     = IDLE;
                        mem_valid_d = 1'b1;
                    end else begin
                        state_d = RESP;
                    end
                end else if (timeout_hit) begin
                    state_d     = IDLE;
                    mem_valid_d = 1'b1;
                    to_d        = 1'b1;
                end
            end
            RESP: begin
                if (i_dmem_rsp_valid) begin
                    state_d     = IDLE;
                    mem_valid_d = 1'b1;
                    regw_d      = regw_q;
                    m2r_d       = 1'b1;
                    load_upd    = 1'b1;
                end else if (timeout_hit) begin
                    state_d     = IDLE;
                    mem_valid_d = 1'b1;
                    to_d        = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture the execute-stage instruction on acceptance
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            result_q <= '0;
            wdata_q  <= '0;
            rd_q     <= '0;
            regw_q   <= 1'b0;
            we_q     <= 1'b0;
            size_q   <= '0;
        end else if (accept) begin
            result_q <= i_IE_result;
            wdata_q  <= i_IE_data_write;
            rd_q     <= i_IE_rd;
            regw_q   <= i_ctrl_reg_write;
            we_q     <= i_ctrl_mem_write;
            size_q   <= i_ctrl_mem_size;
        end
    end

    // Write-back registers: valid pulses, other fields hold until the next update
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mem_valid_q <= 1'b0;
            result_wb_q <= '0;
            rdata_wb_q  <= '0;
            rd_wb_q     <= '0;
            regw_wb_q   <= 1'b0;
            m2r_q       <= 1'b0;
            mis_q       <= 1'b0;
            to_q        <= 1'b0;
        end else begin
            mem_valid_q <= mem_valid_d;
            if (mem_valid_d) begin
                result_wb_q <= result_d;
                rd_wb_q     <= rd_d;
                regw_wb_q   <= regw_d;
                m2r_q       <= m2r_d;
                mis_q       <= mis_d;
                to_q        <= to_d;
            end
            if (load_upd) rdata_wb_q <= load_data;
        end
    end

    // Store lane steering from the captured size and address
    always_comb begin
        be_lanes    = '1;
        wdata_lanes = wdata_q;
        case (size_q)
            MEM_B, MEM_BU: begin
                be_lanes    = BE_WIDTH'(1) << result_q[1:0];
                wdata_lanes = {4{wdata_q[7:0]}};
            end
            MEM_H, MEM_HU: begin
                be_lanes    = result_q[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    mem_load_align u_load_align (
        .rdata_i   (i_dmem_rdata),
        .addr_lo_i (result_q[1:0]),
        .size_i    (size_q),
        .data_o    (load_data)
    );

    assign o_stall          = (state_q != IDLE);
    assign o_dmem_req_valid = req_valid;
    assign o_dmem_addr      = req_valid ? {result_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign o_dmem_we        = req_valid & we_q;
    assign o_dmem_wdata     = req_valid ? wdata_lanes : '0;
    assign o_dmem_be        = req_valid ? be_lanes : '0;

    assign o_MEM_valid      = mem_valid_q;
    assign o_MEM_result     = result_wb_q;
    assign o_MEM_read_data  = rdata_wb_q;
    assign o_MEM_rd         = rd_wb_q;
    assign o_MEM_reg_write  = regw_wb_q;
    assign o_MEM_mem_to_reg = m2r_q;
    assign o_MEM_misalign   = mis_q;
    assign o_MEM_timeout    = to_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage with a transaction-level
// expectation queue and a per-cycle compare process.
// Watchdog scenario is compiled in with `define MEM_ACCESS_TIMEOUT_EN.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_IE_valid, i_ctrl_mem_read, i_ctrl_mem_write, i_ctrl_reg_write;
    logic [31:0] i_IE_result, i_IE_data_write, i_dmem_rdata;
    logic [4:0]  i_IE_rd;
    logic [2:0]  i_ctrl_mem_size;
    logic        i_dmem_req_ready, i_dmem_rsp_valid;
    logic        o_stall, o_dmem_req_valid, o_dmem_we, o_MEM_valid;
    logic [31:0] o_dmem_addr, o_dmem_wdata, o_MEM_result, o_MEM_read_data;
    logic [3:0]  o_dmem_be;
    logic [4:0]  o_MEM_rd;
    logic        o_MEM_reg_write, o_MEM_mem_to_reg, o_MEM_misalign, o_MEM_timeout;

    always #5 clk = ~clk;

    mem_access_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_FILE_ADDR(5), .TIMEOUT_CYCLES(16)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_IE_valid(i_IE_valid), .i_IE_result(i_IE_result), .i_IE_data_write(i_IE_data_write),
        .i_IE_rd(i_IE_rd), .i_ctrl_mem_read(i_ctrl_mem_read), .i_ctrl_mem_write(i_ctrl_mem_write),
        .i_ctrl_reg_write(i_ctrl_reg_write), .i_ctrl_mem_size(i_ctrl_mem_size),
        .o_stall(o_stall), .o_dmem_req_valid(o_dmem_req_valid), .i_dmem_req_ready(i_dmem_req_ready),
        .o_dmem_addr(o_dmem_addr), .o_dmem_we(o_dmem_we), .o_dmem_wdata(o_dmem_wdata),
        .o_dmem_be(o_dmem_be), .i_dmem_rsp_valid(i_dmem_rsp_valid), .i_dmem_rdata(i_dmem_rdata),
        .o_MEM_valid(o_MEM_valid), .o_MEM_result(o_MEM_result), .o_MEM_read_data(o_MEM_read_data),
        .o_MEM_rd(o_MEM_rd), .o_MEM_reg_write(o_MEM_reg_write), .o_MEM_mem_to_reg(o_MEM_mem_to_reg),
        .o_MEM_misalign(o_MEM_misalign), .o_MEM_timeout(o_MEM_timeout)
    );

    typedef struct {
        logic [31:0] result;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        regw, m2r, mis, to;
    } wb_t;

    wb_t         exp_q[$];
    wb_t         held;
    logic [31:0] held_rdata;
    logic [31:0] eb_addr, eb_wdata;
    logic [3:0]  eb_be;
    logic        eb_we;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Spec-level models, plain arithmetic
    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a, input logic [2:0] sz);
        logic [31:0] v;
        int unsigned lane;
        lane = 32'(a[1:0]);
        case (sz)
            3'b000, 3'b100: begin
                v = (w / (32'd1 << (8 * lane))) % 32'd256;
                if (sz == 3'b000 && v >= 32'd128) v = v - 32'd256;
            end
            3'b001, 3'b101: begin
                v = (w / (32'd1 << (16 * (lane / 2)))) % 32'd65536;
                if (sz == 3'b001 && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic model_mis(input logic [2:0] sz, input logic [31:0] a);
        if (sz == 3'b001 || sz == 3'b101) return (a % 2) != 0;
        if (sz == 3'b010) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] sz, input logic [31:0] a);
        if (sz == 3'b000 || sz == 3'b100) return 4'(32'd1 << (a % 4));
        if (sz == 3'b001 || sz == 3'b101) return ((a % 4) >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [2:0] sz);
        if (sz == 3'b000 || sz == 3'b100) return (d % 32'd256) * 32'h01010101;
        if (sz == 3'b001 || sz == 3'b101) return (d % 32'd65536) * 32'h00010001;
        return d;
    endfunction

    // Per-cycle comparison of write-back and bus outputs against the model
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            held       = '{default: '0};
            held_rdata = '0;
        end else begin
            if (o_MEM_valid) begin
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected", {31'b0, o_MEM_valid}, 32'd0);
                end else begin
                    held = exp_q.pop_front();
                    if (held.m2r) held_rdata = held.rdata;
                end
            end
            chk("wb_result", o_MEM_result, held.result);
            chk("wb_rd", {27'b0, o_MEM_rd}, {27'b0, held.rd});
            chk("wb_regw", {31'b0, o_MEM_reg_write}, {31'b0, held.regw});
            chk("wb_m2r", {31'b0, o_MEM_mem_to_reg}, {31'b0, held.m2r});
            chk("wb_mis", {31'b0, o_MEM_misalign}, {31'b0, held.mis});
            chk("wb_to", {31'b0, o_MEM_timeout}, {31'b0, held.to});
            chk("wb_rdata", o_MEM_read_data, held_rdata);
            if (o_dmem_req_valid) begin
                chk("bus_addr", o_dmem_addr, eb_addr);
                chk("bus_we", {31'b0, o_dmem_we}, {31'b0, eb_we});
                if (eb_we) begin
                    chk("bus_be", {28'b0, o_dmem_be}, {28'b0, eb_be});
                    chk("bus_wdata", o_dmem_wdata, eb_wdata);
                end
            end
        end
    end

    task automatic setup(input logic rd_en, input logic wr_en, input logic regw, input logic [2:0] sz,
                         input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd);
        eb_addr          = addr & ~32'h3;
        eb_we            = wr_en;
        eb_be            = model_be(sz, addr);
        eb_wdata         = model_wdata(data, sz);
        i_IE_valid       = 1'b1;
        i_IE_result      = addr;
        i_IE_data_write  = data;
        i_IE_rd          = rd;
        i_ctrl_mem_read  = rd_en;
        i_ctrl_mem_write = wr_en;
        i_ctrl_reg_write = regw;
        i_ctrl_mem_size  = sz;
    endtask

    task automatic do_op(input logic rd_en, input logic wr_en, input logic regw, input logic [2:0] sz,
                         input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd,
                         input int ready_dly, input int rsp_dly, input logic [31:0] rdata, input bit early_rsp);
        wb_t  e;
        logic memop, st, mis;
        memop    = rd_en | wr_en;
        st       = wr_en;
        mis      = memop && model_mis(sz, addr);
        e.result = addr;
        e.rd     = rd;
        e.to     = 1'b0;
        e.mis    = mis;
        e.m2r    = memop && !st && !mis;
        e.regw   = (!memop || e.m2r) ? regw : 1'b0;
        e.rdata  = model_load(rdata, addr, sz);
        @(negedge clk);
        chk("idle_stall", {31'b0, o_stall}, 32'd0);
        exp_q.push_back(e);
        setup(rd_en, wr_en, regw, sz, addr, data, rd);
        @(negedge clk);
        i_IE_valid = 1'b0; i_ctrl_mem_read = 1'b0; i_ctrl_mem_write = 1'b0;
        if (!memop || mis) begin
            chk("lat1_wb", {31'b0, o_MEM_valid}, 32'd1);
            chk("lat1_noreq", {31'b0, o_dmem_req_valid}, 32'd0);
            chk("lat1_stall", {31'b0, o_stall}, 32'd0);
        end else begin
            repeat (ready_dly) begin
                chk("req_wait_valid", {31'b0, o_dmem_req_valid}, 32'd1);
                chk("req_wait_stall", {31'b0, o_stall}, 32'd1);
                @(negedge clk);
            end
            chk("req_valid", {31'b0, o_dmem_req_valid}, 32'd1);
            i_dmem_req_ready = 1'b1;
            if (early_rsp) begin
                i_dmem_rsp_valid = 1'b1;
                i_dmem_rdata     = 32'hDEADBEEF;
            end
            @(negedge clk);
            i_dmem_req_ready = 1'b0;
            i_dmem_rsp_valid = 1'b0;
            if (st) begin
                chk("st_wb_pulse", {31'b0, o_MEM_valid}, 32'd1);
                chk("st_stall_free", {31'b0, o_stall}, 32'd0);
            end else begin
                chk("ld_resp_stall", {31'b0, o_stall}, 32'd1);
                chk("ld_resp_noreq", {31'b0, o_dmem_req_valid}, 32'd0);
                chk("ld_resp_nowb", {31'b0, o_MEM_valid}, 32'd0);
                repeat (rsp_dly) begin
                    @(negedge clk);
                    chk("ld_wait_stall", {31'b0, o_stall}, 32'd1);
                end
                i_dmem_rsp_valid = 1'b1;
                i_dmem_rdata     = rdata;
                @(negedge clk);
                i_dmem_rsp_valid = 1'b0;
                i_dmem_rdata     = '0;
                chk("ld_wb_pulse", {31'b0, o_MEM_valid}, 32'd1);
                chk("ld_stall_free", {31'b0, o_stall}, 32'd0);
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, {31'b0, o_stall}, 32'd0);
        chk({tag, "_req"}, {31'b0, o_dmem_req_valid}, 32'd0);
        chk({tag, "_addr"}, o_dmem_addr, 32'd0);
        chk({tag, "_be"}, {28'b0, o_dmem_be}, 32'd0);
        chk({tag, "_wb"}, {31'b0, o_MEM_valid}, 32'd0);
        chk({tag, "_result"}, o_MEM_result, 32'd0);
        chk({tag, "_rdata"}, o_MEM_read_data, 32'd0);
        chk({tag, "_rd"}, {27'b0, o_MEM_rd}, 32'd0);
        chk({tag, "_flags"}, {28'b0, o_MEM_reg_write, o_MEM_mem_to_reg, o_MEM_misalign, o_MEM_timeout}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        i_IE_valid = 1'b0; i_IE_result = '0; i_IE_data_write = '0; i_IE_rd = '0;
        i_ctrl_mem_read = 1'b0; i_ctrl_mem_write = 1'b0; i_ctrl_reg_write = 1'b0; i_ctrl_mem_size = '0;
        i_dmem_req_ready = 1'b0; i_dmem_rsp_valid = 1'b0; i_dmem_rdata = '0;

        // Model pins from hand-computed values
        chk("pin_lb", model_load(32'h00800000, 32'h102, 3'b000), 32'hFFFFFF80);
        chk("pin_lbu", model_load(32'h00800000, 32'h102, 3'b100), 32'h00000080);
        chk("pin_lh", model_load(32'h80017FFF, 32'h102, 3'b001), 32'hFFFF8001);
        chk("pin_be_sb", {28'b0, model_be(3'b000, 32'h103)}, 32'h8);
        chk("pin_wd_sb", model_wdata(32'h000000AB, 3'b000), 32'hABABABAB);

        #12;
        chk_all_zero("rst");
        @(negedge clk); #2 rst_n = 1'b1;

        // rd_en, wr_en, regw, size, addr, data, rd, ready_dly, rsp_dly, rdata, early_rsp
        do_op(0, 0, 1, 3'b010, 32'h12345678, 32'h0, 5'd5, 0, 0, 32'h0, 0);
        do_op(0, 1, 1, 3'b000, 32'h00000103, 32'h000000AB, 5'd6, 0, 0, 32'h0, 0);
        do_op(1, 0, 1, 3'b000, 32'h00000102, 32'h0, 5'd7, 3, 2, 32'h00800000, 0);
        chk("lb_rdata_lit", o_MEM_read_data, 32'hFFFFFF80);
        do_op(1, 0, 1, 3'b100, 32'h00000102, 32'h0, 5'd8, 3, 2, 32'h00800000, 0);
        chk("lbu_rdata_lit", o_MEM_read_data, 32'h00000080);
        do_op(1, 0, 1, 3'b001, 32'h00000101, 32'h0, 5'd9, 0, 0, 32'h0, 0);
        chk("lh_mis_lit", {31'b0, o_MEM_misalign}, 32'd1);
        do_op(0, 1, 1, 3'b001, 32'h00000102, 32'h1234ABCD, 5'd10, 0, 0, 32'h0, 0);
        do_op(0, 1, 0, 3'b010, 32'h00000104, 32'hCAFEF00D, 5'd11, 1, 0, 32'h0, 0);
        do_op(1, 0, 1, 3'b001, 32'h00000102, 32'h0, 5'd12, 0, 0, 32'h80017FFF, 0);
        do_op(1, 0, 1, 3'b101, 32'h00000100, 32'h0, 5'd13, 0, 1, 32'h12348001, 0);
        do_op(1, 0, 1, 3'b010, 32'h00000108, 32'h0, 5'd14, 0, 0, 32'h89ABCDEF, 1);
        do_op(1, 0, 1, 3'b000, 32'h00000101, 32'h0, 5'd15, 2, 0, 32'h00007F00, 0);
        do_op(1, 1, 1, 3'b000, 32'h00000101, 32'h0000005A, 5'd16, 0, 0, 32'h0, 0);
        do_op(0, 1, 1, 3'b010, 32'h00000106, 32'h11111111, 5'd17, 0, 0, 32'h0, 0);
        do_op(1, 0, 1, 3'b010, 32'h0000010A, 32'h0, 5'd18, 0, 0, 32'h0, 0);
        do_op(1, 0, 0, 3'b010, 32'h0000010C, 32'h0, 5'd19, 0, 0, 32'h76543210, 0);
        do_op(0, 0, 0, 3'b000, 32'hFFFFFFFF, 32'h0, 5'd31, 0, 0, 32'h0, 0);

`ifdef MEM_ACCESS_TIMEOUT_EN
        begin
            wb_t e;
            e = '{result: 32'h200, rdata: 32'h0, rd: 5'd20, regw: 1'b0, m2r: 1'b0, mis: 1'b0, to: 1'b1};
            @(negedge clk);
            exp_q.push_back(e);
            setup(1, 0, 1, 3'b010, 32'h00000200, 32'h0, 5'd20);
            @(negedge clk);
            i_IE_valid = 1'b0; i_ctrl_mem_read = 1'b0;
            repeat (16) begin
                chk("to_req_held", {31'b0, o_dmem_req_valid}, 32'd1);
                @(negedge clk);
            end
            chk("to_req_drop", {31'b0, o_dmem_req_valid}, 32'd0);
            chk("to_wb_pulse", {31'b0, o_MEM_valid}, 32'd1);
            chk("to_stall_free", {31'b0, o_stall}, 32'd0);
        end
`else
        do_op(1, 0, 1, 3'b010, 32'h00000300, 32'h0, 5'd21, 40, 0, 32'h0F0F0F0F, 0);
        chk("wait_no_timeout", {31'b0, o_MEM_timeout}, 32'd0);
`endif

        // Reset while waiting for a load response
        @(negedge clk);
        setup(1, 0, 1, 3'b000, 32'h00000400, 32'h0, 5'd22);
        @(negedge clk);
        i_IE_valid = 1'b0; i_ctrl_mem_read = 1'b0;
        i_dmem_req_ready = 1'b1;
        @(negedge clk);
        i_dmem_req_ready = 1'b0;
        chk("rsp_state_stall", {31'b0, o_stall}, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        @(negedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        i_dmem_rsp_valid = 1'b1;
        i_dmem_rdata     = 32'h000000FF;
        @(negedge clk);
        i_dmem_rsp_valid = 1'b0;
        chk("late_rsp_ignored", {31'b0, o_MEM_valid}, 32'd0);
        chk("late_rsp_stall", {31'b0, o_stall}, 32'd0);
        do_op(0, 0, 1, 3'b000, 32'h0BADF00D, 32'h0, 5'd3, 0, 0, 32'h0, 0);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
